mmu_systolic_2x2: RTL and testbench

2x2 output-stationary systolic matrix-multiply unit computing C = A × B on 8-bit operands. It sits directly downstream of the TPU controller's operand registers. The controller presents the loaded A and B elements and pulses `start`. The unit returns the four C elements, which the controller's output mux then selects onto `uo_out`.

---
 rtl/mmu_systolic_2x2.sv | 199 +++++++++++++++++++
 tb/tb_mmu_systolic_2x2.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mmu_systolic_2x2.sv
// ---------------------------------------------------------------------------
// mmu_systolic_2x2
//   2x2 output-stationary systolic matrix-multiply unit, C = A x B.
//   A start accepted in IDLE latches both operand matrices. Skewed rows of A
//   and columns of B are then fed through a 2x2 PE array over 4 FEED edges,
//   followed by one DRAIN edge. done rises 5 cycles after the accepting edge
//   and holds until the next accepted start or reset.
//
// Ports
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   start   : multiply request, honoured only in IDLE
//   a_flat  : matrix A, element [r][c] at [(2r+c)*DATA_W +: DATA_W]
//   b_flat  : matrix B, same packing as A
//   c_flat  : matrix C, element [r][c] at [(2r+c)*ACC_W +: ACC_W]
//   busy    : multiply in progress
//   done    : C valid (level)
//
// Configuration
//   MMU_SIGNED_EN : when defined, operands/results are two's complement;
//                   otherwise unsigned with zero extension.
// ---------------------------------------------------------------------------
module mmu_systolic_2x2 #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 2*DATA_W+1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DATA_W-1:0]   a_flat,
    input  logic [4*DATA_W-1:0]   b_flat,
    output logic [4*ACC_W-1:0]    c_flat,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FEED,
        S_DRAIN
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   w_accept;

    logic [1:0]             r_t;
    logic                   r_done;
    logic [4*DATA_W-1:0]    r_a_op;
    logic [4*DATA_W-1:0]    r_b_op;

    // r_pa[i][j] / r_pb[i][j] are the a/b registers held by PE(i,j)
    logic [DATA_W-1:0]      r_pa  [2][2];
    logic [DATA_W-1:0]      r_pb  [2][2];
    logic [ACC_W-1:0]       r_acc [2][2];

    logic [DATA_W-1:0]      w_a_in [2];
    logic [DATA_W-1:0]      w_b_in [2];
    logic [2*DATA_W-1:0]    w_mul  [2][2];
    logic [ACC_W-1:0]       w_prod [2][2];

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        busy        = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_FEED;
                end
            end
            S_FEED: begin
                if (r_t == 2'd3) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Skewed boundary feed: row i gets A[i][t-i], column j gets B[t-j][j].
    // Expressed as t == i+k so no negative index is ever formed; any
    // (t, i) pair without a matching k feeds zero.
    // ------------------------------------------------------------------
    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            w_a_in[i] = '0;
            w_b_in[i] = '0;
        end
        if (r_state == S_FEED) begin
            for (int unsigned i = 0; i < 2; i++) begin
                for (int unsigned k = 0; k < 2; k++) begin
                    if (32'(r_t) == i + k) begin
                        w_a_in[i] = r_a_op[(2*i+k)*DATA_W +: DATA_W];
                        w_b_in[i] = r_b_op[(2*k+i)*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // PE products: operands extended to 2*DATA_W so the low half of the
    // plain product equals the signed or unsigned product as required.
    // ------------------------------------------------------------------
    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            for (int unsigned j = 0; j < 2; j++) begin
`ifdef MMU_SIGNED_EN
                w_mul[i][j]  = {{DATA_W{r_pa[i][j][DATA_W-1]}}, r_pa[i][j]}
                             * {{DATA_W{r_pb[i][j][DATA_W-1]}}, r_pb[i][j]};
                w_prod[i][j] = {{(ACC_W-2*DATA_W){w_mul[i][j][2*DATA_W-1]}}, w_mul[i][j]};
`else
                w_mul[i][j]  = {{DATA_W{1'b0}}, r_pa[i][j]}
                             * {{DATA_W{1'b0}}, r_pb[i][j]};
                w_prod[i][j] = {{(ACC_W-2*DATA_W){1'b0}}, w_mul[i][j]};
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath: operand latch, systolic shift and accumulate
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_t    <= '0;
            r_done <= 1'b0;
            r_a_op <= '0;
            r_b_op <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                for (int unsigned j = 0; j < 2; j++) begin
                    r_pa[i][j]  <= '0;
                    r_pb[i][j]  <= '0;
                    r_acc[i][j] <= '0;
                end
            end
        end else if (w_accept) begin
            r_t    <= '0;
            r_done <= 1'b0;
            r_a_op <= a_flat;
            r_b_op <= b_flat;
            for (int unsigned i = 0; i < 2; i++) begin
                for (int unsigned j = 0; j < 2; j++) begin
                    r_pa[i][j]  <= '0;
                    r_pb[i][j]  <= '0;
                    r_acc[i][j] <= '0;
                end
            end
        end else if (r_state != S_IDLE) begin
            if (r_state == S_FEED) begin
                r_t <= r_t + 2'd1;
            end
            if (r_state == S_DRAIN) begin
                r_done <= 1'b1;
            end
            for (int unsigned i = 0; i < 2; i++) begin
                for (int unsigned j = 0; j < 2; j++) begin
                    r_acc[i][j] <= r_acc[i][j] + w_prod[i][j];
                end
                // a moves right along row i, b moves down column i
                r_pa[i][0] <= w_a_in[i];
                r_pa[i][1] <= r_pa[i][0];
                r_pb[0][i] <= w_b_in[i];
                r_pb[1][i] <= r_pb[0][i];
            end
        end
    end

    always_comb begin
        c_flat = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            for (int unsigned j = 0; j < 2; j++) begin
                c_flat[(2*i+j)*ACC_W +: ACC_W] = r_acc[i][j];
            end
        end
    end

    assign done = r_done;

endmodule

// File: tb/tb_mmu_systolic_2x2.sv
// ---------------------------------------------------------------------------
// tb_mmu_systolic_2x2
//   Self-checking bench for mmu_systolic_2x2. Expected C comes from a plain
//   matrix-multiply reference; honours MMU_SIGNED_EN the same way as the DUT.
// ---------------------------------------------------------------------------
module tb_mmu_systolic_2x2;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 2*DATA_W+1;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic [4*DATA_W-1:0]  a_flat;
    logic [4*DATA_W-1:0]  b_flat;
    logic [4*ACC_W-1:0]   c_flat;
    logic                 busy;
    logic                 done;

    int n_checks = 0;
    int n_errors = 0;

    mmu_systolic_2x2 #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a_flat (a_flat),
        .b_flat (b_flat),
        .c_flat (c_flat),
        .busy   (busy),
        .done   (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint elem(input logic [4*DATA_W-1:0] m, input int r, input int c);
        logic [DATA_W-1:0] x;
        x = m[(2*r+c)*DATA_W +: DATA_W];
`ifdef MMU_SIGNED_EN
        return longint'($signed(x));
`else
        return longint'(x);
`endif
    endfunction

    function automatic logic [4*ACC_W-1:0] ref_mm(input logic [4*DATA_W-1:0] a,
                                                  input logic [4*DATA_W-1:0] b);
        logic [4*ACC_W-1:0] res;
        longint s;
        res = '0;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
                s = 0;
                for (int k = 0; k < 2; k++) s += elem(a, r, k) * elem(b, k, c);
                res[(2*r+c)*ACC_W +: ACC_W] = s[ACC_W-1:0];
            end
        end
        return res;
    endfunction

    task automatic check_c(input string tag, input logic [4*ACC_W-1:0] exp);
        for (int e = 0; e < 4; e++) begin
            check($sformatf("%s_c%0d", tag, e),
                  32'(c_flat[e*ACC_W +: ACC_W]), 32'(exp[e*ACC_W +: ACC_W]));
        end
    endtask

    // Wait (bounded) for done; checks latency and busy/done exclusivity.
    // Optionally pulses start with fresh operands at E2 of the run.
    task automatic wait_done(input string tag, input bit poke_e2);
        int cyc;
        cyc = 0;
        while (!done && cyc < 20) begin
            tick();
            cyc++;
            check({tag, "_excl"}, 32'(busy & done), 32'd0);
            if (poke_e2 && cyc == 1) begin
                start  = 1'b1;
                a_flat = $urandom;
                b_flat = $urandom;
            end else if (poke_e2 && cyc == 2) begin
                start = 1'b0;
            end
        end
        check({tag, "_lat"}, 32'(cyc), 32'd5);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // Single multiply from IDLE; operands may be corrupted after E0.
    task automatic run_mult(input string tag, input logic [4*DATA_W-1:0] a,
                            input logic [4*DATA_W-1:0] b, input bit corrupt,
                            input bit poke_e2);
        logic [4*ACC_W-1:0] exp;
        exp    = ref_mm(a, b);
        a_flat = a;
        b_flat = b;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        check({tag, "_e0_busy"}, 32'(busy), 32'd1);
        check({tag, "_e0_done"}, 32'(done), 32'd0);
        if (corrupt) begin
            a_flat = $urandom;
            b_flat = $urandom;
        end
        wait_done(tag, poke_e2);
        check_c(tag, exp);
    endtask

    initial begin
        logic [4*DATA_W-1:0] a1, b1, a2, b2;
        rst_n  = 1'b1;
        start  = 1'b0;
        a_flat = '0;
        b_flat = '0;
        #2;

        // Reset with start asserted
        rst_n  = 1'b0;
        start  = 1'b1;
        a_flat = $urandom;
        b_flat = $urandom;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check_c("rst", '0);
        start = 1'b0;
        rst_n = 1'b1;
        tick();

        run_mult("basic", {8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, 1'b1, 1'b0);
        run_mult("full", '1, '1, 1'b0, 1'b0);
        run_mult("sign", '1, {4{8'h01}}, 1'b0, 1'b0);
        run_mult("busy_start", {8'd9, 8'd200, 8'd17, 8'd33}, {8'd1, 8'd2, 8'd250, 8'd128},
                 1'b0, 1'b1);
        tick();
        check("idle_hold_done", 32'(done), 32'd1);

        for (int n = 0; n < 12; n++) begin
            run_mult($sformatf("rnd%0d", n), $urandom, $urandom, 1'b1, 1'b0);
            repeat ($urandom_range(0, 2)) tick();
        end

        // Back-to-back with start held high
        a1 = $urandom; b1 = $urandom;
        a2 = $urandom; b2 = $urandom;
        a_flat = a1;
        b_flat = b1;
        start  = 1'b1;
        tick();
        wait_done("b2b1", 1'b0);
        check_c("b2b1", ref_mm(a1, b1));
        a_flat = a2;
        b_flat = b2;
        tick();
        check("b2b_restart_done", 32'(done), 32'd0);
        check("b2b_restart_busy", 32'(busy), 32'd1);
        wait_done("b2b2", 1'b0);
        check_c("b2b2", ref_mm(a2, b2));

        // Third restart, then reset at E3
        a_flat = $urandom;
        b_flat = $urandom;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check_c("mid_rst", '0);
        tick();
        rst_n = 1'b1;
        for (int n = 0; n < 6; n++) begin
            tick();
            check("mid_rst_no_done", 32'(done), 32'd0);
        end

        run_mult("post_rst", {8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
